// File: rtl/product_acc_pkg.sv
// rtl/product_acc_pkg.sv - shared widths and state type for the product accumulator
package product_acc_pkg;

    localparam int P_W   = 8;
    localparam int SUM_W = 12;
    localparam int CNT_W = 5;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } acc_state_e;

endpackage

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums up to MAX_TERMS 8-bit products per group
// Results are held until out_ready; one bubble cycle separates consecutive groups.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int MAX_TERMS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [P_W-1:0]   in_p,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [CNT_W-1:0] L_MAX_CNT = CNT_W'(MAX_TERMS);

    acc_state_e       r_state;
    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_trunc;

    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [SUM_W-1:0] w_sum_inc;
    logic             w_at_max;

    assign w_accept  = (r_state == ACC) && in_valid;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_sum_inc = r_sum + {{(SUM_W-P_W){1'b0}}, in_p};
    assign w_at_max  = (w_cnt_inc == L_MAX_CNT);

    // in_ready is gated by rst_n so it reads 0 for the whole reset pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACC;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_trunc <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_accept) begin
                        r_sum <= w_sum_inc;
                        r_cnt <= w_cnt_inc;
                        if (in_last || w_at_max) begin
                            r_state <= DONE;
                            r_trunc <= w_at_max && !in_last;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= ACC;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_trunc <= 1'b0;
                    end
                end
                default: r_state <= ACC;
            endcase
        end
    end

    assign in_ready  = rst_n && (r_state == ACC);
    assign out_valid = (r_state == DONE);
    assign out_sum   = r_sum;
    assign out_count = r_cnt;
    assign out_trunc = r_trunc;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - randomized and directed checks against a group-level model
module tb_product_accumulator;
    import product_acc_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [P_W-1:0]   in_p;
    logic             in_valid;
    logic             in_last;
    logic             out_ready;

    logic             in_ready_w  [2];
    logic [SUM_W-1:0] out_sum_w   [2];
    logic [CNT_W-1:0] out_count_w [2];
    logic             out_trunc_w [2];
    logic             out_valid_w [2];

    int n_total;
    int n_bad;

    int m_max   [2];
    int m_sum   [2];
    int m_cnt   [2];
    bit m_done  [2];
    bit m_trunc [2];

    product_accumulator #(.MAX_TERMS(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_p      (in_p),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready_w[0]),
        .out_sum   (out_sum_w[0]),
        .out_count (out_count_w[0]),
        .out_trunc (out_trunc_w[0]),
        .out_valid (out_valid_w[0]),
        .out_ready (out_ready)
    );

    product_accumulator #(.MAX_TERMS(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_p      (in_p),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready_w[1]),
        .out_sum   (out_sum_w[1]),
        .out_count (out_count_w[1]),
        .out_trunc (out_trunc_w[1]),
        .out_valid (out_valid_w[1]),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_sum[d]   = 0;
            m_cnt[d]   = 0;
            m_done[d]  = 1'b0;
            m_trunc[d] = 1'b0;
        end
    endtask

    // A group collects terms until last or until it holds MAX_TERMS of them.
    task automatic model_edge(input bit v, input int p, input bit l, input bit r);
        for (int d = 0; d < 2; d++) begin
            if (!m_done[d]) begin
                if (v) begin
                    m_sum[d] = m_sum[d] + p;
                    m_cnt[d] = m_cnt[d] + 1;
                    if (l || m_cnt[d] == m_max[d]) begin
                        m_done[d]  = 1'b1;
                        m_trunc[d] = !l;
                    end
                end
            end else if (r) begin
                m_sum[d]   = 0;
                m_cnt[d]   = 0;
                m_done[d]  = 1'b0;
                m_trunc[d] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            string pfx;
            pfx = (d == 0) ? "m16_" : "m4_";
            chk({pfx, "in_ready"},  int'(in_ready_w[d]),  int'(!m_done[d]));
            chk({pfx, "out_valid"}, int'(out_valid_w[d]), int'(m_done[d]));
            chk({pfx, "out_sum"},   int'(out_sum_w[d]),   m_sum[d]);
            chk({pfx, "out_count"}, int'(out_count_w[d]), m_cnt[d]);
            chk({pfx, "out_trunc"}, int'(out_trunc_w[d]), int'(m_trunc[d]));
        end
    endtask

    task automatic step(input bit v, input int p, input bit l, input bit r);
        in_valid  = v;
        in_p      = P_W'(p);
        in_last   = l;
        out_ready = r;
        @(posedge clk);
        model_edge(v, p, l, r);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready16", int'(in_ready_w[0]), 0);
        chk("rst_in_ready4",  int'(in_ready_w[1]), 0);
        chk("rst_out_valid16", int'(out_valid_w[0]), 0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_all();
    endtask

    initial begin
        int terms36 [6];
        n_total   = 0;
        n_bad     = 0;
        m_max[0]  = 16;
        m_max[1]  = 4;
        model_clear();
        rst_n     = 1'b1;
        in_p      = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #2;
        do_reset();
        chk("reset_sum",   int'(out_sum_w[0]), 0);
        chk("reset_count", int'(out_count_w[0]), 0);

        // Group closed by last, result visible for a single cycle.
        terms36 = '{55, 105, 120, 26, 50, 40};
        for (int i = 0; i < 6; i++) step(1'b1, terms36[i], i == 5, 1'b1);
        chk("g36_sum",   int'(out_sum_w[0]), 396);
        chk("g36_count", int'(out_count_w[0]), 6);
        chk("g36_trunc", int'(out_trunc_w[0]), 0);
        chk("g36_valid", int'(out_valid_w[0]), 1);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("g36_valid_once", int'(out_valid_w[0]), 0);

        // Truncation at MAX_TERMS.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 225, 1'b0, i != 15);
        chk("g37_sum",   int'(out_sum_w[0]), 3600);
        chk("g37_count", int'(out_count_w[0]), 16);
        chk("g37_trunc", int'(out_trunc_w[0]), 1);
        chk("g37_ready", int'(in_ready_w[0]), 0);
        step(1'b1, 225, 1'b0, 1'b1);

        // Backpressure holds the result.
        do_reset();
        step(1'b1, 70, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 9, 1'b1, 1'b0);
            chk("g38_hold_sum", int'(out_sum_w[0]), 70);
            chk("g38_hold_rdy", int'(in_ready_w[0]), 0);
        end
        step(1'b0, 0, 1'b0, 1'b1);
        chk("g38_cleared", int'(out_sum_w[0]), 0);
        chk("g38_acc",     int'(in_ready_w[0]), 1);

        // Idle gaps inside a group.
        do_reset();
        step(1'b1, 10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 200, 1'b1, 1'b0);
        step(1'b1, 20, 1'b1, 1'b0);
        chk("g39_sum",   int'(out_sum_w[0]), 30);
        chk("g39_count", int'(out_count_w[0]), 2);
        step(1'b0, 0, 1'b0, 1'b1);

        // Reset discards a partial group.
        do_reset();
        step(1'b1, 100, 1'b0, 1'b1);
        step(1'b1, 100, 1'b0, 1'b1);
        do_reset();
        step(1'b1, 5, 1'b1, 1'b0);
        chk("g40_sum",   int'(out_sum_w[0]), 5);
        chk("g40_count", int'(out_count_w[0]), 1);
        step(1'b0, 0, 1'b0, 1'b1);

        // Last on the MAX_TERMS-th term is not a truncation.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, i, i == 4, 1'b0);
        chk("g41_sum",   int'(out_sum_w[1]), 10);
        chk("g41_count", int'(out_count_w[1]), 4);
        chk("g41_trunc", int'(out_trunc_w[1]), 0);
        chk("g41_valid", int'(out_valid_w[1]), 1);
        step(1'b0, 0, 1'b0, 1'b1);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7, int'($urandom_range(0, 225)),
                     $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 6);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter MAX_TERMS, default 16, meaning the maximum number of products summed per result (legal range 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port in_p, input, 8, unsigned product from the upstream 4x4 multiplier (0..225).
REQ-005 SHALL have port in_valid, input, 1, meaning in_p and in_last are valid.
REQ-006 SHALL have port in_last, input, 1, meaning the product is the final term of the current group.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts a term this cycle.
REQ-008 SHALL have port out_sum, output, 12, unsigned group sum.
REQ-009 SHALL have port out_count, output, 5, number of terms in out_sum (1..MAX_TERMS).
REQ-010 SHALL have port out_trunc, output, 1, meaning the group closed on MAX_TERMS without in_last.
REQ-011 SHALL have port out_valid, output, 1, meaning out_sum, out_count and out_trunc are valid.
REQ-012 SHALL have port out_ready, input, 1, meaning the downstream consumes the result.

Function
REQ-013 SHALL implement a 2-state FSM: ACC and DONE.
REQ-014 In ACC: in_ready=1 and out_valid=0.
REQ-015 In DONE: in_ready=0 and out_valid=1.
REQ-016 A term is accepted when in_valid and in_ready are both 1 on a rising clk edge; no other condition accepts a term.
REQ-017 On accept: sum <= sum + in_p (zero-extended to 12 bits) and count <= count + 1.
REQ-018 Transition ACC->DONE: on accept when in_last=1, OR on accept when count+1 == MAX_TERMS.
REQ-019 Trunc rule at ACC->DONE: out_trunc <= 1 only if the transition was caused by count+1 == MAX_TERMS with in_last=0; otherwise 0.
REQ-020 Term that is both last and the MAX_TERMS-th: out_trunc=0.
REQ-021 Latency: out_valid SHALL assert on the first cycle after the accepting edge of the closing term.
REQ-022 Outputs SHALL be registered; out_sum and out_count SHALL expose the accumulator directly.
REQ-023 Hold: in DONE with out_ready=0, all outputs SHALL stay stable.
REQ-024 Transition DONE->ACC: when out_ready=1; on that edge sum, count and out_trunc clear to 0.
REQ-025 Bubble: one mandatory bubble cycle between groups; no term is accepted in DONE.
REQ-026 Overflow SHALL be impossible: 16*225 = 3600 < 4096; no saturation logic.
REQ-027 in_valid=0 in ACC SHALL leave all state unchanged (idle wait, no timeout).
REQ-028 in_p and in_last SHALL be ignored when no term is accepted.

Reset
REQ-029 rst_n=0 SHALL immediately force state=ACC, sum=0, count=0, out_trunc=0, out_valid=0, in_ready=1 (after release).
REQ-030 in_ready SHALL be 0 while rst_n=0.
REQ-031 Reset mid-group or in DONE SHALL discard the partial/pending result with no output.
REQ-032 Reset release SHALL be synchronous to clk at the integration level; the first accept is possible on the first edge after release.

Structure
REQ-033 Shared package product_acc_pkg SHALL hold: P_W=8, SUM_W=12, CNT_W=5, and the state enum {ACC, DONE}.
REQ-034 No sub-module: counter, adder and FSM are inline in one module.
REQ-035 Upstream multiplier_4bit is instantiated by the integrating top, not here.

Verification
REQ-036 Group close by last: terms 55,105,120,26,50,40 with last on 40, out_ready=1 -> out_sum=396, out_count=6, out_trunc=0, out_valid for exactly 1 cycle.
REQ-037 Truncation: 16 terms of 225, in_last=0 -> out_sum=3600, out_count=16, out_trunc=1; in_ready=0 on the following cycle.
REQ-038 Backpressure: single term 70 with last, out_ready=0 for 5 cycles then 1 -> outputs stable for 5 cycles, in_ready=0 throughout, return to ACC with sum=0.
REQ-039 Gaps: terms 10 and 20 (last) with 3 idle in_valid=0 cycles between -> out_sum=30, out_count=2.
REQ-040 Reset mid-group: accept 100,100, assert rst_n=0, then send 5 (last) -> out_sum=5, out_count=1; no result 200 ever appears.
REQ-041 Last on the MAX_TERMS-th term: with MAX_TERMS=4, terms 1,2,3,4 with last on 4 -> out_sum=10, out_count=4, out_trunc=0.
